memwb_pipe_stage: RTL and testbench
===================================

// Module: memwb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage with a valid/ready handshake, stall and flush.
//  Carries the writeback payload {load, rf_we, mem_data, alu_res, rd} from the memory stage to the register-file write port.
//  Unlike a plain clocked register, it holds its contents under back-pressure and kills writeback side effects on flush.
//  It also counts stall cycles for performance monitoring.
// PARAMETERS
//  DATA_W     32  width of mem_data and alu_res fields
//  RD_W       4   destination register index width
//  STALL_CW   16  width of saturating stall-cycle counter
// PORTS
//  CLK          in   1         rising-edge clock
//  CLR_N        in   1         asynchronous active-low reset
//  in_valid     in   1         MEM stage presents a payload
//  in_ready     out  1         stage can accept the payload this cycle
//  in_load      in   1         payload: instruction is a load
//  in_rf        in   1         payload: register-file write enable
//  in_mem_data  in   DATA_W    payload: data-memory read value
//  in_alu       in   DATA_W    payload: ALU result / address
//  in_rd        in   RD_W      payload: destination register
//  flush        in   1         kill all held payloads (branch/exception)
//  out_valid    out  1         WB payload valid
//  out_ready    in   1         WB consumes the payload this cycle
//  out_load     out  1         registered in_load
//  out_rf       out  1         registered in_rf, gated by out_valid (0 when invalid)
//  out_mem_data out  DATA_W    registered in_mem_data
//  out_alu      out  DATA_W    registered in_alu
//  out_rd       out  RD_W      registered in_rd
//  stall_cnt    out  STALL_CW  cycles with out_valid & ~out_ready, saturating at all-ones
// BEHAVIOUR
//  - Reset (CLR_N=0, async): all outputs 0, stall_cnt 0, skid empty; in_ready reads 1 after release.
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency is 1 cycle, in -> out.
//  - Main register loads when (~out_valid | out_ready). Otherwise it holds all fields unchanged.
//  - Simultaneous accept and consume: the new payload replaces the old one, keeping full throughput of 1 per cycle.
//  - Consume without accept: out_valid -> 0. out_rf, out_load -> 0. Data fields hold their last value.
//  - flush (sync, highest priority): next cycle out_valid=0, out_rf=0, out_load=0, skid emptied.
//    The in_valid payload presented during the flush cycle is dropped. in_ready is unaffected.
//  - stall_cnt increments when out_valid & ~out_ready & ~flush. It holds at 2^STALL_CW-1 and never wraps.
//  - out_rf is never 1 while out_valid=0, so WB cannot write the register file on a bubble.
// CONFIGURATION
//  MEMWB_SKID_EN defined:
//    - in_ready comes straight from a flop (= skid empty). There is no combinational out_ready->in_ready path.
//    - A payload accepted while the main register is blocked goes into the one-entry skid.
//    - On the next consume, the skid moves to main and the skid empties. in_ready drops for exactly the cycles the skid is full.
//  MEMWB_SKID_EN undefined:
//    - There is no skid. in_ready = ~out_valid | out_ready (combinational).
// STRUCTURE
//  - Package memwb_pkg holds the typedef struct packed memwb_payload_t {load, rf, mem_data, alu, rd} and the zero constant MEMWB_NOP.
//  - Sub-module memwb_skid_slot holds one payload entry plus its valid flag with load/clear controls. It is instantiated only under MEMWB_SKID_EN.
//  - The top level contains the main register, the handshake control and the stall counter.
// TESTING
//  - Reset mid-stream: CLR_N low while out_valid=1 -> all outputs 0 immediately, before any clock edge; stall_cnt=0.
//  - Streaming: in_valid=1, out_ready=1, alu=1..8 -> out_alu=1..8 one cycle later, out_valid steady 1, stall_cnt stays 0.
//  - Back-pressure: out_ready=0 for 5 cycles with out_rd=4'hA held -> payload unchanged, stall_cnt=5.
//      SKID_EN: in_ready=0 after one extra accept; no payload lost or duplicated.
//  - Flush: flush=1 with valid rf=1, rd=4'h3 and skid full -> next cycle out_valid=0, out_rf=0, in_ready=1.
//  - Saturation: STALL_CW=4, 20 stall cycles -> stall_cnt=4'hF, holds.
//  - Bubble: in_valid=0, in_rf=1 -> out_valid=0 and out_rf=0 after 1 cycle.

Source files
------------

// File: rtl/memwb_pkg.sv
// memwb_pkg: shared payload type, default widths and NOP constant for the MEM->WB stage.
package memwb_pkg;
  localparam int MEMWB_DATA_W = 32;
  localparam int MEMWB_RD_W   = 4;
  typedef struct packed {
    logic                    load;
    logic                    rf;
    logic [MEMWB_DATA_W-1:0] mem_data;
    logic [MEMWB_DATA_W-1:0] alu;
    logic [MEMWB_RD_W-1:0]   rd;
  } memwb_payload_t;
  localparam memwb_payload_t MEMWB_NOP = '0;
endpackage

// File: rtl/memwb_skid_slot.sv
// memwb_skid_slot: one payload entry plus valid flag; clear wins over load.
module memwb_skid_slot #(
  parameter int W = 70
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         v_o
);
  logic [W-1:0] data_q;
  logic         v_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      data_q <= '0;
      v_q    <= 1'b0;
    end else if (clr_i) begin
      v_q    <= 1'b0;
    end else if (ld_i) begin
      data_q <= d_i;
      v_q    <= 1'b1;
    end
  assign q_o = data_q;
  assign v_o = v_q;
endmodule

// File: rtl/memwb_pipe_stage.sv
// memwb_pipe_stage: MEM->WB register with valid/ready, flush and saturating stall counter.
// Define MEMWB_SKID_EN to add a one-entry skid so in_ready comes from a flop.
module memwb_pipe_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W   = MEMWB_DATA_W,
  parameter int RD_W     = MEMWB_RD_W,
  parameter int STALL_CW = 16
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_load,
  input  logic                in_rf,
  input  logic [DATA_W-1:0]   in_mem_data,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_load,
  output logic                out_rf,
  output logic [DATA_W-1:0]   out_mem_data,
  output logic [DATA_W-1:0]   out_alu,
  output logic [RD_W-1:0]     out_rd,
  output logic [STALL_CW-1:0] stall_cnt
);
  typedef struct packed {
    logic              load;
    logic              rf;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
  } payload_t;
  payload_t            in_pl, main_d, main_q;
  logic                valid_d, valid_q, main_en, accept;
  logic [STALL_CW-1:0] stall_d, stall_q;
  assign in_pl   = '{load: in_load, rf: in_rf, mem_data: in_mem_data, alu: in_alu, rd: in_rd};
  assign main_en = ~valid_q | out_ready;
`ifdef MEMWB_SKID_EN
  payload_t skid_pl;
  logic     skid_v, skid_ld;
  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign skid_ld  = accept & ~main_en & ~flush;
  memwb_skid_slot #(.W($bits(payload_t))) u_skid (
    .clk_i (CLK),
    .rst_ni(CLR_N),
    .ld_i  (skid_ld),
    .clr_i (flush | (main_en & skid_v)),
    .d_i   (in_pl),
    .q_o   (skid_pl),
    .v_o   (skid_v)
  );
  // A full skid always drains into main first; in_ready is low then, so no accept competes.
  always_comb begin
    valid_d = flush ? 1'b0 : main_en ? (skid_v | accept) : valid_q;
    main_d  = (flush | ~main_en) ? main_q : skid_v ? skid_pl : accept ? in_pl : main_q;
  end
`else
  assign in_ready = main_en;
  assign accept   = in_valid & in_ready;
  always_comb begin
    valid_d = flush ? 1'b0 : main_en ? accept : valid_q;
    main_d  = (~flush & accept) ? in_pl : main_q;
  end
`endif
  assign stall_d = (valid_q & ~out_ready & ~flush & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      valid_q <= 1'b0;
      main_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  // Side-effect bits are gated so a bubble or flushed entry can never write back.
  assign out_valid    = valid_q;
  assign out_load     = main_q.load & valid_q;
  assign out_rf       = main_q.rf & valid_q;
  assign out_mem_data = main_q.mem_data;
  assign out_alu      = main_q.alu;
  assign out_rd       = main_q.rd;
  assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_memwb_pipe_stage.sv
// tb_memwb_pipe_stage: scoreboard bench; driver pushes accepted payloads, monitor pops on consume.
`timescale 1ns/1ps
module tb_memwb_pipe_stage;
  typedef struct packed {
    logic        ld;
    logic        rf;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [3:0]  rd;
  } pl_t;
  logic        CLK = 1'b0;
  logic        CLR_N = 1'b1;
  logic        in_valid = 1'b0, in_load = 1'b0, in_rf = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_mem_data = '0, in_alu = '0;
  logic [3:0]  in_rd = '0;
  logic        in_ready, out_valid, out_load, out_rf;
  logic [31:0] out_mem_data, out_alu;
  logic [3:0]  out_rd, stall_cnt;
  pl_t         sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  memwb_pipe_stage #(.DATA_W(32), .RD_W(4), .STALL_CW(4)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_rf(in_rf), .in_mem_data(in_mem_data), .in_alu(in_alu),
    .in_rd(in_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_load(out_load), .out_rf(out_rf), .out_mem_data(out_mem_data),
    .out_alu(out_alu), .out_rd(out_rd), .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic step(input logic v, ld, rf, input logic [31:0] mem, alu,
                      input logic [3:0] rd, input logic ordy, fl);
    @(negedge CLK);
    in_valid = v; in_load = ld; in_rf = rf; in_mem_data = mem; in_alu = alu;
    in_rd = rd; out_ready = ordy; flush = fl;
    #1;
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back('{ld, rf, mem, alu, rd});
  endtask
  task automatic do_reset();
    #1;
    CLR_N = 1'b0;
    sb.delete();
    #1;
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_rf", 80'(out_rf), 80'(0));
    chk("rst_load", 80'(out_load), 80'(0));
    chk("rst_data", 80'({out_mem_data, out_alu, out_rd}), 80'(0));
    chk("rst_stall", 80'(stall_cnt), 80'(0));
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge CLK);
    CLR_N = 1'b1;
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'(1));
  endtask
  // Monitor: samples just before each rising edge, well away from it.
  initial forever begin
    @(negedge CLK);
    #3;
    if (!out_valid) chk("bubble_gate", 80'({out_rf, out_load}), 80'(0));
    else if (out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 80'(out_alu), 80'(0) - 80'(1));
      else chk("sb_payload", 80'({out_load, out_rf, out_mem_data, out_alu, out_rd}), 80'(sb.pop_front()));
    end
  end
  initial begin
    do_reset();
    // Streaming at full throughput
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 1, 32'(k * 256), 32'(k), 4'(k), 1, 0);
      if (k >= 2) begin
        chk("stream_valid", 80'(out_valid), 80'(1));
        chk("stream_alu", 80'(out_alu), 80'(k - 1));
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("stream_last", 80'({out_valid, out_alu}), 80'({1'b1, 32'd8}));
    chk("stream_stall", 80'(stall_cnt), 80'(0));
    // Reset mid-stream while out_valid=1
    do_reset();
    // Back-pressure
    step(1, 0, 1, 32'h55, 32'h10, 4'hA, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 1, 32'h66, 32'h20, 4'hB, 0, 0);
`ifdef MEMWB_SKID_EN
      chk("bp_in_ready", 80'(in_ready), 80'(k == 1));
`else
      chk("bp_in_ready", 80'(in_ready), 80'(0));
`endif
      chk("bp_rd_hold", 80'({out_valid, out_rd}), 80'({1'b1, 4'hA}));
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp_alu_hold", 80'(out_alu), 80'(32'h10));
    chk("bp_stall5", 80'(stall_cnt), 80'(5));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp_stall_keep", 80'(stall_cnt), 80'(5));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp_drained", 80'(out_valid), 80'(0));
    // Flush with valid rf=1 rd=3 held and (when present) skid full
    do_reset();
    step(1, 1, 1, 32'h77, 32'h30, 4'h3, 1, 0);
    step(1, 0, 1, 32'h88, 32'h40, 4'h4, 0, 0);
    chk("fl_pre", 80'({out_valid, out_rf, out_rd}), 80'({1'b1, 1'b1, 4'h3}));
    step(1, 0, 1, 32'h99, 32'h50, 4'h5, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("fl_valid", 80'(out_valid), 80'(0));
    chk("fl_rf_load", 80'({out_rf, out_load}), 80'(0));
    chk("fl_in_ready", 80'(in_ready), 80'(1));
    chk("fl_stall", 80'(stall_cnt), 80'(1));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("fl_skid_dead", 80'(out_valid), 80'(0));
    // Bubble: data holds, side effects gated
    step(1, 0, 1, 32'hAB, 32'hCD, 4'h7, 1, 0);
    step(0, 1, 1, 32'h11, 32'h22, 4'h9, 1, 0);
    chk("bub_pre", 80'({out_valid, out_rf, out_rd}), 80'({1'b1, 1'b1, 4'h7}));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("bub_gate", 80'({out_valid, out_rf, out_load}), 80'(0));
    chk("bub_alu_hold", 80'(out_alu), 80'(32'hCD));
    // Saturation of 4-bit stall counter
    do_reset();
    step(1, 0, 0, 0, 32'h1, 4'h1, 1, 0);
    for (int k = 0; k < 15; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_reach", 80'(stall_cnt), 80'(4'hF));
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_hold", 80'(stall_cnt), 80'(4'hF));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("sb_empty", 80'(sb.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
